// File: rtl/maze_scenario_player_pkg.sv
// Shared types for the maze scenario player: step word layout and sequencer states.
// step_t uses the default widths; the player builds its own copy from its parameters.
package maze_scn_pkg;

  localparam int THETA_W_DEF = 13;
  localparam int DUR_W_DEF   = 24;

  function automatic int step_w(input int theta_w, input int dur_w);
    return theta_w + dur_w + 5;
  endfunction

  localparam int STEP_W = step_w(THETA_W_DEF, DUR_W_DEF);

  typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_t;

  typedef struct packed {
    logic                          chk_theta;
    logic                          chk_buzz;
    logic                          bmpl_n;
    logic                          bmpr_n;
    logic                          line_pres;
    logic signed [THETA_W_DEF-1:0] theta;
    logic [DUR_W_DEF-1:0]          dur;
  } step_t;

endpackage

// File: rtl/maze_scenario_player_if.sv
// Bundle between the scenario player and its loader / MazePhysics / DUT hookup.
interface maze_scn_if
  import maze_scn_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int THETA_W = 13,
  parameter int DUR_W   = 24
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = step_w(THETA_W, DUR_W);

  logic                      wr_en;
  logic [AW-1:0]             wr_addr;
  logic [SW-1:0]             wr_data;
  logic [AW:0]               num_steps;
  logic                      start;
  logic                      abort;
  logic signed [THETA_W-1:0] theta_robot;
  logic                      buzz;
  logic signed [THETA_W-1:0] line_theta;
  logic                      line_present;
  logic                      BMPL_n;
  logic                      BMPR_n;
  logic                      busy;
  logic                      done;
  logic                      pass;
  logic [AW-1:0]             fail_step;
  logic                      fail_theta;

  modport master (
    output wr_en, wr_addr, wr_data, num_steps, start, abort, theta_robot, buzz,
    input  line_theta, line_present, BMPL_n, BMPR_n, busy, done, pass, fail_step, fail_theta
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, num_steps, start, abort, theta_robot, buzz,
    output line_theta, line_present, BMPL_n, BMPR_n, busy, done, pass, fail_step, fail_theta
  );

endinterface

// File: rtl/maze_scenario_player_step_timer.sv
// Loadable step-duration down-counter; expire marks the last cycle of a step.
module scn_step_timer #(
  parameter int DUR_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [DUR_W-1:0] load_val,
  output logic             expire
);

  logic [DUR_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst)                cnt_q <= '0;
    else if (load)          cnt_q <= load_val;
    else if (cnt_q != '0)   cnt_q <= cnt_q - DUR_W'(1);
  end

  assign expire = (cnt_q == DUR_W'(1));

endmodule

// File: rtl/maze_scenario_player.sv
// Timed step-table sequencer driving maze stimulus and checking heading / buzzer per step.
// state | meaning: IDLE - waiting for start | RUN - step stimulus applied | CHECK - judge step | DONE - result held
module maze_scenario_player
  import maze_scn_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int THETA_W = 13,
  parameter int DUR_W   = 24,
  parameter int TOL     = 16
) (
  input logic       clk,
  input logic       rst,
  maze_scn_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int NW = AW + 1;
  localparam logic [THETA_W:0] TOL_V = (THETA_W+1)'(TOL);

  typedef struct packed {
    logic                      chk_theta;
    logic                      chk_buzz;
    logic                      bmpl_n;
    logic                      bmpr_n;
    logic                      line_pres;
    logic signed [THETA_W-1:0] theta;
    logic [DUR_W-1:0]          dur;
  } word_t;

  word_t step_mem [DEPTH];

  state_t                    state_q, state_n;
  logic [AW-1:0]             idx_q, idx_n, fail_step_q, fail_step_n;
  logic [NW-1:0]             num_q, num_n;
  logic                      seen_q, seen_n, pass_q, pass_n, fail_theta_q, fail_theta_n;
  logic signed [THETA_W-1:0] line_theta_q;
  logic                      line_pres_q, bmpl_q, bmpr_q, chk_theta_q, chk_buzz_q;
  logic                      enter, stim_idle, expire, theta_bad, buzz_bad;
  word_t                     enter_word;
  logic [DUR_W-1:0]          load_val;
  logic [AW-1:0]             idx_inc;
  logic signed [THETA_W:0]   diff;
  logic [THETA_W:0]          adiff;

  always_ff @(posedge clk) begin
    if (bus.wr_en && (state_q == IDLE || state_q == DONE))
      step_mem[bus.wr_addr] <= bus.wr_data;
  end

  assign idx_inc  = idx_q + AW'(1);
  assign load_val = (enter_word.dur == '0) ? DUR_W'(1) : enter_word.dur;

  // line_theta_q holds the current step's target through RUN and CHECK
  assign diff  = $signed({bus.theta_robot[THETA_W-1], bus.theta_robot})
               - $signed({line_theta_q[THETA_W-1], line_theta_q});
  assign adiff = diff[THETA_W] ? $unsigned(-diff) : $unsigned(diff);
  assign theta_bad = chk_theta_q && (adiff > TOL_V);
  assign buzz_bad  = chk_buzz_q && !seen_q;

  scn_step_timer #(.DUR_W(DUR_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (enter),
    .load_val (load_val),
    .expire   (expire)
  );

  always_comb begin
    state_n      = state_q;
    idx_n        = idx_q;
    num_n        = num_q;
    seen_n       = seen_q;
    pass_n       = pass_q;
    fail_step_n  = fail_step_q;
    fail_theta_n = fail_theta_q;
    enter        = 1'b0;
    enter_word   = step_mem[0];
    stim_idle    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          num_n        = bus.num_steps;
          pass_n       = 1'b0;
          fail_step_n  = '0;
          fail_theta_n = 1'b0;
          if (bus.num_steps == '0 || bus.num_steps > NW'(DEPTH)) begin
            state_n = DONE;
          end else begin
            state_n = RUN;
            idx_n   = '0;
            enter   = 1'b1;
          end
        end
      end
      RUN: begin
        seen_n = seen_q | bus.buzz;
        if (expire) state_n = CHECK;
      end
      CHECK: begin
        if (theta_bad || buzz_bad) begin
          state_n      = DONE;
          fail_step_n  = idx_q;
          fail_theta_n = theta_bad;
          stim_idle    = 1'b1;
        end else if (NW'(idx_q) + NW'(1) == num_q) begin
          state_n   = DONE;
          pass_n    = 1'b1;
          stim_idle = 1'b1;
        end else begin
          state_n    = RUN;
          idx_n      = idx_inc;
          enter      = 1'b1;
          enter_word = step_mem[idx_inc];
        end
      end
      default: state_n = IDLE;
    endcase
    if (bus.abort && (state_q == RUN || state_q == CHECK)) begin
      state_n      = IDLE;
      pass_n       = 1'b0;
      fail_step_n  = '0;
      fail_theta_n = 1'b0;
      enter        = 1'b0;
      stim_idle    = 1'b1;
    end
    if (enter) seen_n = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      num_q        <= '0;
      seen_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_step_q  <= '0;
      fail_theta_q <= 1'b0;
      line_theta_q <= '0;
      line_pres_q  <= 1'b1;
      bmpl_q       <= 1'b1;
      bmpr_q       <= 1'b1;
      chk_theta_q  <= 1'b0;
      chk_buzz_q   <= 1'b0;
    end else begin
      state_q      <= state_n;
      idx_q        <= idx_n;
      num_q        <= num_n;
      seen_q       <= seen_n;
      pass_q       <= pass_n;
      fail_step_q  <= fail_step_n;
      fail_theta_q <= fail_theta_n;
      if (stim_idle) begin
        line_theta_q <= '0;
        line_pres_q  <= 1'b1;
        bmpl_q       <= 1'b1;
        bmpr_q       <= 1'b1;
        chk_theta_q  <= 1'b0;
        chk_buzz_q   <= 1'b0;
      end else if (enter) begin
        line_theta_q <= enter_word.theta;
        line_pres_q  <= enter_word.line_pres;
        bmpl_q       <= enter_word.bmpl_n;
        bmpr_q       <= enter_word.bmpr_n;
        chk_theta_q  <= enter_word.chk_theta;
        chk_buzz_q   <= enter_word.chk_buzz;
      end
    end
  end

  assign bus.line_theta   = line_theta_q;
  assign bus.line_present = line_pres_q;
  assign bus.BMPL_n       = bmpl_q;
  assign bus.BMPR_n       = bmpr_q;
  assign bus.busy         = (state_q == RUN) || (state_q == CHECK);
  assign bus.done         = (state_q == DONE);
  assign bus.pass         = pass_q;
  assign bus.fail_step    = fail_step_q;
  assign bus.fail_theta   = fail_theta_q;

endmodule

// File: tb/tb_maze_scenario_player.sv
// Bench for maze_scenario_player: hand-computed scenario table, random runs against a cycle-window model.
module tb_maze_scenario_player;
  import maze_scn_pkg::*;

  localparam int DEPTH = 16;
  localparam int TOL   = 16;
  localparam int NCYC  = 4100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  maze_scn_if #(.DEPTH(DEPTH), .THETA_W(13), .DUR_W(24)) bus ();

  maze_scenario_player #(.DEPTH(DEPTH), .THETA_W(13), .DUR_W(24), .TOL(TOL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  step_t tb_tbl [DEPTH];
  int    in_th  [NCYC];
  bit    in_bz  [NCYC];
  int    rec_lt [NCYC];
  bit    rec_lp [NCYC], rec_bl [NCYC], rec_br [NCYC], rec_busy [NCYC];
  int    exp_lt [NCYC];
  bit    exp_lp [NCYC], exp_bl [NCYC], exp_br [NCYC], exp_busy [NCYC];
  int    rec_n, dut_done_t, rec_fs;
  bit    rec_pass, rec_ft;
  int    exp_done_t, exp_fs;
  bit    exp_pass, exp_ft;
  int    ph_tgt, ph_age;

  typedef struct {
    int tbl; bit load; int num; int mode; int fth; int ba; int bb; int rs; int wc;
    int e_done; bit e_pass; int e_fs; bit e_ft;
  } vec_t;
  vec_t vecs[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic step_t mk(bit ct, bit cb, bit bl, bit br, bit lp, int th, int dur);
    step_t s;
    s.chk_theta = ct; s.chk_buzz = cb; s.bmpl_n = bl; s.bmpr_n = br; s.line_pres = lp;
    s.theta = 13'(th); s.dur = 24'(dur);
    return s;
  endfunction

  task automatic wr_step(input int a, input step_t s);
    bus.wr_en = 1'b1; bus.wr_addr = 4'(a); bus.wr_data = s;
    tick();
    bus.wr_en = 1'b0;
    tb_tbl[a] = s;
  endtask

  task automatic load_table(input int id);
    if (id == 0) begin
      wr_step(0, mk(0, 0, 1, 1, 1, 0, 1500));
      wr_step(1, mk(0, 0, 1, 1, 1, 150, 1000));
      wr_step(2, mk(0, 0, 1, 1, 0, 150, 300));
      wr_step(3, mk(1, 0, 1, 1, 1, 500, 1000));
    end else begin
      wr_step(0, mk(0, 0, 1, 1, 1, 0, 5));
      wr_step(1, mk(0, 1, 1, 0, 1, 0, 10));
      wr_step(2, mk(1, 1, 1, 1, 1, 0, 0));
    end
  endtask

  // mode 0: robot follows line_theta 200 cycles after it changes; 1: forced; 2: random jitter + random buzz
  task automatic run_scn(input int num, input int mode, input int fth, input int ba, input int bb,
                         input int rs, input int wc, input int limit);
    int r;
    bus.num_steps = 5'(num);
    bus.buzz = 1'b0;
    if (mode == 1) bus.theta_robot = 13'(fth);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    dut_done_t = 0;
    rec_n = limit;
    for (int t = 1; t <= limit; t++) begin
      rec_lt[t] = int'(bus.line_theta); rec_lp[t] = bus.line_present;
      rec_bl[t] = bus.BMPL_n; rec_br[t] = bus.BMPR_n; rec_busy[t] = bus.busy;
      if (bus.done) begin
        dut_done_t = t; rec_n = t;
        break;
      end
      bus.start = (t == rs);
      bus.wr_en = (t == wc);
      bus.wr_addr = 4'd1;
      bus.wr_data = mk(0, 0, 1, 1, 1, 0, 0);
      if (mode == 0) begin
        if (int'(bus.line_theta) != ph_tgt) begin ph_tgt = int'(bus.line_theta); ph_age = 0; end
        else if (ph_age < 1000) ph_age++;
        if (ph_age >= 200) bus.theta_robot = 13'(ph_tgt);
      end else if (mode == 1) begin
        bus.theta_robot = 13'(fth);
      end else begin
        r = int'($urandom_range(50)) - 25;
        bus.theta_robot = 13'(int'(bus.line_theta) + r);
      end
      if (mode == 2) bus.buzz = ($urandom_range(7) == 0);
      else           bus.buzz = (t == ba) || (t == bb);
      in_th[t] = int'(bus.theta_robot);
      in_bz[t] = bus.buzz;
      tick();
    end
    bus.start = 1'b0; bus.wr_en = 1'b0; bus.buzz = 1'b0;
    rec_pass = bus.pass; rec_fs = int'(bus.fail_step); rec_ft = bus.fail_theta;
  endtask

  // Step k owns cycles [t, t+D] (D = max(dur,1)); heading judged on the input of cycle t+D,
  // buzzer on any buzz in cycles t..t+D-1; result visible on the cycle after.
  task automatic model(input int num);
    int t, d, dd, th;
    bit seen, tbad, bbad;
    exp_pass = 0; exp_fs = 0; exp_ft = 0;
    for (int i = 0; i < NCYC; i++) begin
      exp_lt[i] = 0; exp_lp[i] = 1; exp_bl[i] = 1; exp_br[i] = 1; exp_busy[i] = 0;
    end
    if (num < 1 || num > DEPTH) begin exp_done_t = 1; return; end
    t = 1;
    for (int k = 0; k < num; k++) begin
      d = (tb_tbl[k].dur == 0) ? 1 : int'(tb_tbl[k].dur);
      th = tb_tbl[k].theta;
      seen = 0;
      for (int c = t; c <= t + d; c++) begin
        exp_lt[c] = th; exp_lp[c] = tb_tbl[k].line_pres;
        exp_bl[c] = tb_tbl[k].bmpl_n; exp_br[c] = tb_tbl[k].bmpr_n; exp_busy[c] = 1;
        if (c < t + d) seen |= in_bz[c];
      end
      dd = in_th[t + d] - th;
      if (dd < 0) dd = -dd;
      tbad = tb_tbl[k].chk_theta && (dd > TOL);
      bbad = tb_tbl[k].chk_buzz && !seen;
      t = t + d + 1;
      if (tbad || bbad) begin
        exp_fs = k; exp_ft = tbad; exp_done_t = t;
        return;
      end
    end
    exp_pass = 1;
    exp_done_t = t;
  endtask

  task automatic compare_model(input string nm);
    int bad, lim;
    bad = 0;
    lim = (rec_n < exp_done_t) ? rec_n : exp_done_t;
    for (int t = 1; t <= lim; t++)
      if (rec_lt[t] != exp_lt[t] || rec_lp[t] != exp_lp[t] || rec_bl[t] != exp_bl[t] ||
          rec_br[t] != exp_br[t] || rec_busy[t] != exp_busy[t]) bad++;
    check({nm, " done cycle"}, dut_done_t, exp_done_t);
    check({nm, " pass"}, rec_pass, exp_pass);
    check({nm, " fail_step"}, rec_fs, exp_fs);
    check({nm, " fail_theta"}, rec_ft, exp_ft);
    check({nm, " stimulus cycles wrong"}, bad, 0);
  endtask

  initial begin
    bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0; bus.num_steps = '0;
    bus.start = 0; bus.abort = 0; bus.theta_robot = '0; bus.buzz = 0;
    ph_tgt = 0; ph_age = 0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("reset line_theta", bus.line_theta, 0);
    check("reset line_present", bus.line_present, 1);
    check("reset BMPL_n", bus.BMPL_n, 1);
    check("reset BMPR_n", bus.BMPR_n, 1);
    check("reset busy", bus.busy, 0);
    check("reset done", bus.done, 0);
    check("reset pass", bus.pass, 0);
    check("reset fail_step", bus.fail_step, 0);
    check("reset fail_theta", bus.fail_theta, 0);

    //                tbl load num mode fth  ba  bb rs wc done  pass fs ft
    vecs.push_back('{0, 1, 4,  0, 0,    0,  0,  0, 0, 3805, 1, 0, 0});
    vecs.push_back('{0, 0, 4,  1, 400,  0,  0,  0, 0, 3805, 0, 3, 1});
    vecs.push_back('{1, 1, 3,  1, 0,    10, 18, 0, 0, 20,   1, 0, 0});
    vecs.push_back('{1, 0, 3,  1, 0,    0,  0,  0, 0, 18,   0, 1, 0});
    vecs.push_back('{1, 0, 3,  1, 0,    10, 0,  0, 0, 20,   0, 2, 0});
    vecs.push_back('{1, 0, 3,  1, 40,   10, 0,  0, 0, 20,   0, 2, 1});
    vecs.push_back('{1, 0, 3,  1, 16,   10, 18, 0, 0, 20,   1, 0, 0});
    vecs.push_back('{1, 0, 3,  1, -17,  10, 18, 0, 0, 20,   0, 2, 1});
    vecs.push_back('{1, 0, 1,  1, 0,    0,  0,  0, 0, 7,    1, 0, 0});
    vecs.push_back('{1, 0, 0,  1, 0,    0,  0,  0, 0, 1,    0, 0, 0});
    vecs.push_back('{1, 0, 17, 1, 0,    0,  0,  0, 0, 1,    0, 0, 0});
    vecs.push_back('{1, 0, 3,  1, 0,    10, 18, 8, 0, 20,   1, 0, 0});
    vecs.push_back('{1, 0, 3,  1, 0,    0,  0,  0, 3, 18,   0, 1, 0});
    vecs.push_back('{1, 0, 3,  1, 0,    0,  0,  0, 0, 18,   0, 1, 0});

    foreach (vecs[i]) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      if (vecs[i].load) load_table(vecs[i].tbl);
      run_scn(vecs[i].num, vecs[i].mode, vecs[i].fth, vecs[i].ba, vecs[i].bb,
              vecs[i].rs, vecs[i].wc, 4000);
      check({nm, " done cycle const"}, dut_done_t, vecs[i].e_done);
      check({nm, " pass const"}, rec_pass, vecs[i].e_pass);
      check({nm, " fail_step const"}, rec_fs, vecs[i].e_fs);
      check({nm, " fail_theta const"}, rec_ft, vecs[i].e_ft);
      model(vecs[i].num);
      compare_model(nm);
    end

    // abort mid-step (with a simultaneous start) during step 1 of table B
    bus.num_steps = 5'd3; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("abort busy before", bus.busy, 1);
    repeat (8) tick();
    check("abort BMPR_n in step1", bus.BMPR_n, 0);
    bus.abort = 1'b1; bus.start = 1'b1;
    tick();
    bus.abort = 1'b0; bus.start = 1'b0;
    check("abort busy", bus.busy, 0);
    check("abort done", bus.done, 0);
    check("abort BMPR_n", bus.BMPR_n, 1);
    check("abort pass", bus.pass, 0);
    tick();
    check("abort beats start", bus.busy, 0);

    // synchronous reset mid-run
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (8) tick();
    check("rst BMPR_n before", bus.BMPR_n, 0);
    rst = 1'b1;
    tick();
    check("rst busy", bus.busy, 0);
    check("rst done", bus.done, 0);
    check("rst BMPR_n", bus.BMPR_n, 1);
    check("rst line_theta", bus.line_theta, 0);
    rst = 1'b0;
    tick();
    run_scn(3, 1, 0, 10, 18, 0, 0, 100);
    model(3);
    compare_model("after rst");

    // random tables, first one uses every entry
    for (int r = 0; r < 30; r++) begin
      int num;
      num = (r == 0) ? DEPTH : int'($urandom_range(DEPTH, 1));
      for (int a = 0; a < DEPTH; a++)
        wr_step(a, mk($urandom_range(2) == 0, $urandom_range(3) == 0, 1'($urandom_range(1)),
                      1'($urandom_range(1)), 1'($urandom_range(1)),
                      int'($urandom_range(600)) - 300, int'($urandom_range(5))));
      run_scn(num, 2, 0, 0, 0, 0, 0, 300);
      model(num);
      compare_model($sformatf("rand%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
